// File: rtl/maq_mh.sv
// Minutes/hours timekeeping stage: BCD minutes and hours, time-set FSM driven by
// the mode/increment buttons, seconds-restart request and day-rollover pulse.
module maq_mh #(
   parameter int SYNC_STAGES = 2,
   parameter bit H24         = 1'b1
) (
   input  logic       maqs_clock,
   input  logic       maqs_reset,
   input  logic       mh_min_carry,
   input  logic       mh_btn_mode,
   input  logic       mh_btn_inc,
   output logic [3:0] mh_min_lsd,
   output logic [2:0] mh_min_msd,
   output logic [3:0] mh_hour_lsd,
   output logic [1:0] mh_hour_msd,
   output logic       mh_pm,
   output logic       mh_set_min,
   output logic       mh_set_hour,
   output logic       mh_sec_clear,
   output logic       mh_day_pulse
);

   localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      SET_HOUR = 2'd1,
      SET_MIN  = 2'd2
   } state_t;

   typedef struct packed {
      logic [2:0] msd;
      logic [3:0] lsd;
   } min_t;

   typedef struct packed {
      logic [1:0] msd;
      logic [3:0] lsd;
      logic       pm;
   } hour_t;

   // Reset time: 00:00 in 24-hour mode, 12:00 AM in 12-hour mode.
   localparam hour_t HOUR_RST = H24 ? hour_t'({2'd0, 4'd0, 1'b0})
                                    : hour_t'({2'd1, 4'd2, 1'b0});

   state_t        state_q;
   state_t        state_nx;
   min_t          min_q;
   min_t          min_nx;
   hour_t         hour_q;
   hour_t         hour_nx;
   logic          carry_p0;
   logic          carry_p1;
   logic [SS-1:0] mode_sync;
   logic [SS-1:0] inc_sync;
   logic          mode_prev;
   logic          inc_prev;
   logic          inc_min;
   logic          mode_ev;
   logic          inc_ev;
   logic          min_wrap;
   logic          day_roll;

   function automatic min_t min_inc(input min_t m);
      min_t r;
      r = m;
      if (m.lsd >= 4'd9) begin
         r.lsd = 4'd0;
         r.msd = (m.msd >= 3'd5) ? 3'd0 : m.msd + 3'd1;
      end else begin
         r.lsd = m.lsd + 4'd1;
      end
      return r;
   endfunction

   // 12-hour mode counts 12,01..11,12 and flips pm on the 11->12 step.
   function automatic hour_t hour_inc(input hour_t h);
      hour_t r;
      r = h;
      if (H24) begin
         if (h.msd >= 2'd2 && h.lsd >= 4'd3) begin
            r.msd = 2'd0;
            r.lsd = 4'd0;
         end else if (h.lsd >= 4'd9) begin
            r.msd = h.msd + 2'd1;
            r.lsd = 4'd0;
         end else begin
            r.lsd = h.lsd + 4'd1;
         end
      end else begin
         if (h.msd >= 2'd1 && h.lsd >= 4'd2) begin
            r.msd = 2'd0;
            r.lsd = 4'd1;
         end else if (h.msd == 2'd1 && h.lsd == 4'd1) begin
            r.msd = 2'd1;
            r.lsd = 4'd2;
            r.pm  = ~h.pm;
         end else if (h.lsd >= 4'd9) begin
            r.msd = 2'd1;
            r.lsd = 4'd0;
         end else begin
            r.lsd = h.lsd + 4'd1;
         end
      end
      return r;
   endfunction

   // Input stage: carry register plus button synchronisers and edge detectors
   always_ff @(posedge maqs_clock or posedge maqs_reset) begin
      if (maqs_reset) begin
         carry_p0  <= 1'b0;
         carry_p1  <= 1'b0;
         mode_sync <= '0;
         inc_sync  <= '0;
         mode_prev <= 1'b0;
         inc_prev  <= 1'b0;
      end else begin
         carry_p0  <= mh_min_carry;
         carry_p1  <= carry_p0;
         mode_sync <= {mode_sync[SS-2:0], mh_btn_mode};
         inc_sync  <= {inc_sync[SS-2:0], mh_btn_inc};
         mode_prev <= mode_sync[SS-1];
         inc_prev  <= inc_sync[SS-1];
      end
   end

   assign inc_min = carry_p0 & ~carry_p1;
   assign mode_ev = mode_sync[SS-1] & ~mode_prev;
   assign inc_ev  = inc_sync[SS-1] & ~inc_prev;

   assign min_nx   = min_inc(min_q);
   assign hour_nx  = hour_inc(hour_q);
   assign min_wrap = (min_q.msd >= 3'd5) && (min_q.lsd >= 4'd9);
   assign day_roll = H24 ? (hour_q.msd == 2'd2 && hour_q.lsd == 4'd3)
                         : (hour_q.pm && !hour_nx.pm);

   always_comb begin
      state_nx = state_q;
      case (state_q)
         RUN:      if (mode_ev) state_nx = SET_HOUR;
         SET_HOUR: if (mode_ev) state_nx = SET_MIN;
         SET_MIN:  if (mode_ev) state_nx = RUN;
         default:  state_nx = RUN;
      endcase
   end

   always_ff @(posedge maqs_clock or posedge maqs_reset) begin
      if (maqs_reset) begin
         state_q     <= RUN;
         mh_set_hour <= 1'b0;
         mh_set_min  <= 1'b0;
      end else begin
         state_q     <= state_nx;
         mh_set_hour <= (state_nx == SET_HOUR);
         mh_set_min  <= (state_nx == SET_MIN);
      end
   end

   // Time stage: digits, pulses; a simultaneous mode event suppresses inc
   always_ff @(posedge maqs_clock or posedge maqs_reset) begin
      if (maqs_reset) begin
         min_q        <= '0;
         hour_q       <= HOUR_RST;
         mh_day_pulse <= 1'b0;
         mh_sec_clear <= 1'b0;
      end else begin
         mh_day_pulse <= 1'b0;
         mh_sec_clear <= (state_q == SET_MIN) && mode_ev;
         case (state_q)
            RUN: begin
               if (inc_min) begin
                  min_q <= min_nx;
                  if (min_wrap) begin
                     hour_q       <= hour_nx;
                     mh_day_pulse <= day_roll;
                  end
               end
            end
            SET_HOUR: if (inc_ev && !mode_ev) hour_q <= hour_nx;
            SET_MIN:  if (inc_ev && !mode_ev) min_q <= min_nx;
            default: ;
         endcase
      end
   end

   assign mh_min_lsd  = min_q.lsd;
   assign mh_min_msd  = min_q.msd;
   assign mh_hour_lsd = hour_q.lsd;
   assign mh_hour_msd = hour_q.msd;
   assign mh_pm       = H24 ? 1'b0 : hour_q.pm;

endmodule
